// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, shifts
// one byte out on device clock falls, checks the device ACK and waits for bus idle.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code,
  output logic [2:0] dbg_state
);

  // Handshake: a byte is accepted on any clk edge where tx_valid && tx_ready.
  // tx_ready is high only in IDLE; tx_valid seen while busy is ignored and
  // tx_data need only be stable in the accepting cycle.

  localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_C = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
  localparam int CW    = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NOACK   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [9:0]    shift, shift_n;
  logic          ps2c_prev;
  logic          fall;
  logic          tracked;
  logic          c_oe_n, d_oe_n, done_n, err_n;
  logic [1:0]    code_n;

  assign fall      = ps2c_prev & ~ps2c_in;
  assign dbg_state = state;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    c_oe_n   = ps2c_oe;
    d_oe_n   = ps2d_oe;
    done_n   = 1'b0;
    err_n    = 1'b0;
    code_n   = err_code;
    tracked  = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);

    // The one counter doubles as the frame watchdog once the clock is released;
    // its expiry wins over a fall arriving in the same cycle.
    if (tracked && (cnt == TO_LAST)) begin
      c_oe_n  = 1'b0;
      d_oe_n  = 1'b0;
      err_n   = 1'b1;
      code_n  = ERR_TIMEOUT;
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          c_oe_n = 1'b0;
          d_oe_n = 1'b0;
          if (tx_valid && tx_ready) begin
            shift_n = {1'b1, ~^tx_data, tx_data};
            code_n  = 2'b00;
            cnt_n   = '0;
            c_oe_n  = 1'b1;
            state_n = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          c_oe_n = 1'b1;
          d_oe_n = 1'b0;
          if (cnt == INH_LAST) begin
            cnt_n   = '0;
            d_oe_n  = 1'b1;
            state_n = S_RTS;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_RTS: begin
          c_oe_n = 1'b1;
          d_oe_n = 1'b1;
          if (cnt == RTS_LAST) begin
            c_oe_n   = 1'b0;
            cnt_n    = '0;
            bitcnt_n = '0;
            state_n  = S_SHIFT;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_SHIFT: begin
          cnt_n = cnt + CW'(1);
          if (fall) begin
            d_oe_n   = ~shift[bitcnt];
            bitcnt_n = bitcnt + 4'd1;
            if (bitcnt == 4'd9) state_n = S_ACK;
          end
        end
        S_ACK: begin
          cnt_n = cnt + CW'(1);
          if (fall) begin
            if (!ps2d_in) begin
              state_n = S_WAIT_IDLE;
            end else begin
              c_oe_n  = 1'b0;
              d_oe_n  = 1'b0;
              err_n   = 1'b1;
              code_n  = ERR_NOACK;
              state_n = S_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          cnt_n = cnt + CW'(1);
          if (ps2c_in && ps2d_in) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
        default: begin
          c_oe_n  = 1'b0;
          d_oe_n  = 1'b0;
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      shift     <= '0;
      ps2c_prev <= 1'b1;
      ps2c_oe   <= 1'b0;
      ps2d_oe   <= 1'b0;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bitcnt    <= bitcnt_n;
      shift     <= shift_n;
      ps2c_prev <= ps2c_in;
      ps2c_oe   <= c_oe_n;
      ps2d_oe   <= d_oe_n;
      tx_ready  <= (state_n == S_IDLE);
      busy      <= (state_n != S_IDLE);
      tx_done   <= done_n;
      tx_error  <= err_n;
      err_code  <= code_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on a wired-AND bus, frame reference
// model with an expected-frame queue, directed corner cases and randomized frames.
module tb_ps2_host_tx;

  localparam int INH   = 40;
  localparam int RTSC  = 8;
  localparam int TO    = 3000;
  localparam int LIMIT = 6000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2c_oe, ps2d_oe, busy, tx_done, tx_error;
  logic [1:0] err_code;
  logic [2:0] dbg_state;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2c_in, ps2d_in;

  // Open-collector bus: either side may pull a line low.
  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_dat & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTSC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .busy     (busy),
    .tx_done  (tx_done),
    .tx_error (tx_error),
    .err_code (err_code),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          hp = 12;
  logic [10:0] exp_q[$];
  logic [10:0] got_bits;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_done;
    logic [1:0] exp_code;
  } vec_t;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference frame in sampling order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: present a byte, return at the first negedge after it was accepted
  task automatic send(input logic [7:0] d, input bit hold);
    int n;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("accept_busy", busy, 1);
    check("accept_code_clear", err_code, 0);
    if (!hold) tx_valid = 1'b0;
    exp_q.push_back(frame_of(d));
  endtask

  // device model: samples data on every clock rise, the first being the host release
  task automatic dev_frame(input int nfalls, input bit ack);
    int n;
    got_bits = '0;
    n = 0;
    while (ps2c_oe && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("clk_released", ps2c_oe, 0);
    got_bits[0] = ps2d_in;
    for (int k = 1; k <= nfalls; k++) begin
      wait_neg(hp);
      dev_clk = 1'b0;
      wait_neg(hp);
      dev_clk = 1'b1;
      got_bits[k] = ps2d_in;
    end
    if (nfalls == 10) begin
      if (ack) dev_dat = 1'b0;
      wait_neg(hp);
      dev_clk = 1'b0;
      wait_neg(hp);
      dev_clk = 1'b1;
      wait_neg(hp);
      dev_dat = 1'b1;
    end
  endtask

  // scoreboard
  task automatic check_frame(input string name);
    logic [10:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    check(name, got_bits, e);
  endtask

  task automatic wait_end(input int base);
    int n;
    n = 0;
    while ((done_cnt + err_cnt) == base && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("end_seen", done_cnt + err_cnt, base + 1);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input bit exp_done,
                           input logic [1:0] exp_code, input string tag);
    int d0, e0;
    send(d, 1'b0);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_frame(10, ack);
    check_frame({tag, "_bits"});
    wait_end(d0 + e0);
    wait_neg(2);
    check({tag, "_done"}, done_cnt - d0, exp_done ? 1 : 0);
    check({tag, "_err"}, err_cnt - e0, exp_done ? 0 : 1);
    check({tag, "_code"}, err_code, exp_code);
    check({tag, "_lines"}, {ps2c_oe, ps2d_oe}, 2'b00);
    check({tag, "_idle"}, {tx_ready, busy}, 2'b10);
  endtask

  initial begin
    vec_t vecs[5];
    int   d0, e0, n, n_inh, n_rts;
    logic [7:0] rd;
    bit   rack;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 2'b00};
    vecs[1] = '{8'h80, 1'b1, 1'b1, 2'b00};
    vecs[2] = '{8'h7E, 1'b0, 1'b0, 2'b01};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 2'b00};
    vecs[4] = '{8'h01, 1'b0, 1'b0, 2'b01};

    reset = 1'b1;
    wait_neg(3);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_oe", {ps2c_oe, ps2d_oe}, 2'b00);
    check("rst_pulses", {tx_done, tx_error}, 2'b00);
    check("rst_code", err_code, 0);
    reset = 1'b0;
    wait_neg(2);

    // 0xED with ACK
    run_frame(8'hED, 1'b1, 1'b1, 2'b00, "t1");

    // 0xFF: inhibit and RTS durations, parity bit
    send(8'hFF, 1'b0);
    d0 = done_cnt;
    e0 = err_cnt;
    n_inh = 0;
    while (ps2c_oe && !ps2d_oe && n_inh < LIMIT) begin
      n_inh++;
      @(negedge clk);
    end
    n_rts = 0;
    while (ps2c_oe && ps2d_oe && n_rts < LIMIT) begin
      n_rts++;
      @(negedge clk);
    end
    check("t2_inhibit_len", n_inh, INH);
    check("t2_rts_len", n_rts, RTSC);
    check("t2_start_held", ps2d_oe, 1);
    dev_frame(10, 1'b1);
    check("t2_parity", got_bits[9], 1);
    check_frame("t2_bits");
    wait_end(d0 + e0);
    wait_neg(2);
    check("t2_done", done_cnt - d0, 1);

    // no ACK, then err_code held
    run_frame(8'h3C, 1'b0, 1'b0, 2'b01, "t3");
    wait_neg(5);
    check("t3_code_held", err_code, 2'b01);

    // device never clocks: timeout
    send(8'h12, 1'b0);
    void'(exp_q.pop_front());
    n = 0;
    while (ps2c_oe && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_error && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_len", n, TO);
    check("t4_code", err_code, 2'b10);
    check("t4_lines", {ps2c_oe, ps2d_oe}, 2'b00);
    @(negedge clk);
    check("t4_ready_after", tx_ready, 1);

    // reset after fall 4 of 0x55, then 0xF4 completes
    send(8'h55, 1'b0);
    void'(exp_q.pop_front());
    d0 = done_cnt;
    e0 = err_cnt;
    dev_frame(4, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_lines_released", {ps2c_oe, ps2d_oe}, 2'b00);
    check("t5_idle", {tx_ready, busy}, 2'b10);
    reset = 1'b0;
    wait_neg(3);
    check("t5_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    run_frame(8'hF4, 1'b1, 1'b1, 2'b00, "t5b");

    // tx_valid held with 0xAA during a busy 0xED
    d0 = done_cnt;
    send(8'hED, 1'b1);
    tx_data = 8'hAA;
    dev_frame(10, 1'b1);
    check_frame("t6_first_bits");
    n = 0;
    while (!tx_done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t6_first_done", tx_done, 1);
    check("t6_ready_at_done", tx_ready, 1);
    @(negedge clk);
    check("t6_second_accept", {busy, ps2c_oe}, 2'b11);
    tx_valid = 1'b0;
    exp_q.push_back(frame_of(8'hAA));
    dev_frame(10, 1'b1);
    check_frame("t6_second_bits");
    n = 0;
    while (!tx_done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    wait_neg(3);
    check("t6_two_done", done_cnt - d0, 2);

    // table vectors
    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_done, vecs[i].exp_code, "vec");

    // randomized frames against the model
    for (int i = 0; i < 8; i++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      hp   = $urandom_range(4, 20);
      run_frame(rd, rack, rack, rack ? 2'b00 : 2'b01, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
